// File: rtl/sm83_irq_ctl.sv
// SM83-style interrupt controller: IME with delayed EI, HALT, and a 5 M-cycle dispatch.
// Define SM83_IRQ_HALT_BUG_EN to emulate the HALT bug instead of entering HALT.
module sm83_irq_ctl #(
    parameter int NUM_IRQS   = 5,
    parameter int ADR_WIDTH  = 16,
    parameter int VEC_BASE   = 'h40,
    parameter int VEC_STRIDE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ncyc,
    input  logic                 insn_end,
    input  logic [NUM_IRQS-1:0]  irq,
    input  logic                 ei,
    input  logic                 di,
    input  logic                 reti,
    input  logic                 halt_req,
    output logic                 ime,
    output logic                 dispatch,
    output logic [ADR_WIDTH-1:0] vec,
    output logic                 vec_valid,
    output logic [NUM_IRQS-1:0]  iack,
    output logic                 halted,
    output logic                 halt_bug,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_DISP = 2'd2
    } state_t;

    state_t                state;
    logic [2:0]            mcnt;
    logic                  ei_pend;
    logic [NUM_IRQS-1:0]   sel_onehot;
    logic [ADR_WIDTH-1:0]  sel_vec;
    logic                  any_irq;
    logic                  insn_done;
    logic                  ei_arm;
    logic                  run_take;
    logic                  halt_wake;
    logic                  enter_disp;
    logic                  sel_strobe;
    logic                  halt_enter;

    // Lowest index wins: scan from the top so the last hit is the lowest line.
    always_comb begin
        sel_onehot = '0;
        sel_vec    = '0;
        for (int i = NUM_IRQS - 1; i >= 0; i--) begin
            if (irq[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_vec       = ADR_WIDTH'(VEC_BASE + i * VEC_STRIDE);
            end
        end
    end

    assign any_irq    = |irq;
    assign insn_done  = ncyc && insn_end;
    assign ei_arm     = ei_pend || ei;
    assign run_take   = (state == ST_RUN) && insn_done && ime && any_irq;
    assign halt_wake  = (state == ST_HALT) && ncyc && any_irq;
    assign enter_disp = run_take || (halt_wake && ime);
    assign sel_strobe = (state == ST_DISP) && ncyc && (mcnt == 3'd2);

`ifdef SM83_IRQ_HALT_BUG_EN
    logic halt_trap;
    assign halt_trap  = (state == ST_RUN) && insn_done && halt_req && !ime && any_irq;
    assign halt_enter = insn_done && halt_req && !run_take && !halt_trap;
    assign halt_bug   = halt_trap && !reset;
`else
    assign halt_enter = insn_done && halt_req && !run_take;
    assign halt_bug   = 1'b0;
`endif

    // vec is meaningful only while vec_valid is high; both are registered and
    // cleared together so vec reads as zero whenever vec_valid is low.
    assign iack      = (sel_strobe && !reset) ? sel_onehot : '0;
    assign dispatch  = (state == ST_DISP);
    assign halted    = (state == ST_HALT);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            mcnt      <= 3'd0;
            ime       <= 1'b0;
            ei_pend   <= 1'b0;
            vec       <= '0;
            vec_valid <= 1'b0;
        end else begin
            // IME decisions use the registered value, giving the one-instruction EI delay.
            if (di) begin
                ime     <= 1'b0;
                ei_pend <= 1'b0;
            end else begin
                if (enter_disp) begin
                    ime <= 1'b0;
                end else if (reti || (insn_done && ei_arm)) begin
                    ime <= 1'b1;
                end
                ei_pend <= ei_arm && !insn_done;
            end

            case (state)
                ST_RUN: begin
                    mcnt <= 3'd0;
                    if (enter_disp) begin
                        state <= ST_DISP;
                    end else if (halt_enter) begin
                        state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    mcnt <= 3'd0;
                    if (halt_wake) begin
                        state <= ime ? ST_DISP : ST_RUN;
                    end
                end
                ST_DISP: begin
                    if (ncyc) begin
                        if (mcnt == 3'd2) begin
                            vec       <= sel_vec;
                            vec_valid <= 1'b1;
                        end
                        if (mcnt == 3'd4) begin
                            state     <= ST_RUN;
                            mcnt      <= 3'd0;
                            vec       <= '0;
                            vec_valid <= 1'b0;
                        end else begin
                            mcnt <= mcnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_RUN;
                    mcnt  <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/sm83_irq_ctl.md
SM83_IRQ_CTL -- requirements
Module: sm83_irq_ctl

Interface
REQ-001 SHALL have parameter NUM_IRQS, default 5, number of interrupt request lines (1..16).
REQ-002 SHALL have parameter ADR_WIDTH, default 16, vector address width.
REQ-003 SHALL have parameter VEC_BASE, default 'h40, vector of line 0.
REQ-004 SHALL have parameter VEC_STRIDE, default 8, address distance between consecutive vectors.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 ncyc  in  1  one-clk strobe marking the end of each M-cycle.
REQ-008 insn_end  in  1  asserted with the ncyc strobe that ends an instruction's last M-cycle.
REQ-009 irq  in  NUM_IRQS  level, pending-and-enabled request per line.
REQ-010 ei / di / reti  in  1 each  one-clk pulses from instruction decode.
REQ-011 halt_req  in  1  pulse coincident with insn_end of HALT.
REQ-012 ime  out  1  interrupt master enable.
REQ-013 dispatch  out  1  high for the whole interrupt dispatch sequence.
REQ-014 vec  out  ADR_WIDTH  dispatch target address; vec_valid out 1 qualifies it.
REQ-015 iack  out  NUM_IRQS  one-hot, one-clk acknowledge of the serviced line.
REQ-016 halted  out  1  core stopped; halt_bug out 1  one-clk pulse, suppress next PC increment.

Function
REQ-017 Priority SHALL be lowest index wins; vec = VEC_BASE + idx*VEC_STRIDE, truncated to ADR_WIDTH.
REQ-018 di SHALL clear ime and any pending EI on the next clk; reti SHALL set ime on the next clk.
REQ-019 ei SHALL arm an EI-pending flag; ime SHALL become 1 at the first insn_end at or after the ei pulse, and the dispatch decision at that insn_end SHALL use the pre-update ime (one-instruction delay).
REQ-020 Simultaneous di with ei or reti: di SHALL win.
REQ-021 States: RUN, HALT, DISP; transitions occur only on ncyc.
REQ-022 RUN -> DISP when insn_end && ime && |irq; dispatch SHALL assert from the next clk.
REQ-023 DISP SHALL last exactly 5 M-cycles (D1..D5, counted by ncyc); ime SHALL clear on DISP entry.
REQ-024 Line selection SHALL occur at the ncyc ending D3 using irq at that clk; iack pulses the same clk; vec/vec_valid held from D4 through end of D5.
REQ-025 If irq==0 at end of D3: vec SHALL be 0, vec_valid 1, iack remains 0.
REQ-026 At end of D5 SHALL return to RUN; vec_valid drops; a new dispatch is possible only at a later insn_end.
REQ-027 halt_req with ime==0 and |irq: no halt, halt_bug behaviour per REQ-035; otherwise RUN -> HALT, halted=1 next clk.
REQ-028 In HALT, at any ncyc with |irq: halted clears; if ime==1 enter DISP directly, else RUN.
REQ-029 ei/di/reti during DISP or HALT SHALL still update ime per REQ-018..020.
REQ-030 vec SHALL be 0 and iack 0 whenever vec_valid==0 / outside the REQ-024 strobe.

Reset
REQ-031 Reset SHALL force: state RUN, ime=0, EI-pending=0, dispatch=0, vec=0, vec_valid=0, iack=0, halted=0, halt_bug=0.
REQ-032 Reset mid-DISP SHALL abort with no iack pulse that cycle.
REQ-033 Reset SHALL take priority over all simultaneous inputs.

Configuration
REQ-034 Macro SM83_IRQ_HALT_BUG_EN SHALL select halt-bug emulation.
REQ-035 Defined: case of REQ-027 pulses halt_bug for one clk with the insn_end; undefined: halt_bug tied 0 and the case enters HALT then wakes on the next ncyc per REQ-028.

Verification
REQ-036 ei, then NOP insn_end with irq=5'b00100 -> ime 1 after EI end, no dispatch at EI end, dispatch at NOP end, iack=5'b00100, vec='h50.
REQ-037 irq=5'b10110 at D3 end -> iack=5'b00010, vec='h48; irq dropped to 0 before D3 end -> vec=0, vec_valid=1, no iack.
REQ-038 ime=0, halt_req, irq=0 -> halted=1; irq=5'b00001 -> halted=0 next ncyc, no dispatch; repeat with ime=1 -> dispatch, vec='h40.
REQ-039 ime=0, irq=1, halt_req -> with macro halt_bug one pulse, halted stays 0; without macro halt_bug never asserts.
REQ-040 ei and di same clk -> ime stays 0; reset asserted during D4 -> all outputs reset next clk, no iack.
